// File: rtl/radix2_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Quotient and remainder are produced together and held until the next accepted start.
module radix2_divider #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 finished,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic [BIT_WIDTH-1:0] remainder,
  output logic [1:0]           dbg_state
);

  localparam int W  = BIT_WIDTH;
  localparam int CW = $clog2(BIT_WIDTH);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  // Handshake: start is sampled only while busy=0; finished is a one-cycle pulse
  // in DONE, and quotient/remainder are valid from that cycle until the next accepted start.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  rem_q, shift_q, dsr_q, quo_q, rmd_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q_q, neg_r_q;

  logic          a_neg, b_neg, div_zero, ovf, ge;
  logic [W-1:0]  a_mag, b_mag, diff;

  always_comb begin
    a_neg    = is_signed & dividend[W-1];
    b_neg    = is_signed & divisor[W-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    ovf      = is_signed && (dividend == INT_MIN) && (divisor == '1);
    // The shifted partial remainder needs W+1 bits; the true difference always fits in W.
    ge       = ({rem_q, shift_q[W-1]} >= {1'b0, dsr_q});
    diff     = {rem_q[W-2:0], shift_q[W-1]} - dsr_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    finished  = (state_q == DONE);
    dbg_state = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (div_zero || ovf) ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == '0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rem_q   <= '0;
      shift_q <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            rem_q   <= '0;
            shift_q <= a_mag;
            dsr_q   <= b_mag;
            cnt_q   <= CW'(BIT_WIDTH - 1);
            if (div_zero) begin
              quo_q <= '1;
              rmd_q <= dividend;
            end else if (ovf) begin
              quo_q <= INT_MIN;
              rmd_q <= '0;
            end
          end
        end
        DIVIDE: begin
          cnt_q   <= cnt_q - CW'(1);
          shift_q <= {shift_q[W-2:0], ge};
          rem_q   <= ge ? diff : {rem_q[W-2:0], shift_q[W-1]};
        end
        FIXUP: begin
          quo_q <= neg_q_q ? -shift_q : shift_q;
          rmd_q <= neg_r_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: directed vectors, arithmetic reference model,
// per-cycle output check against an expected queue.
module tb_radix2_divider;
  localparam int W = 32;
  localparam logic [W-1:0] INT_MIN = 32'h8000_0000;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend, divisor;
  logic         busy, finished;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  radix2_divider #(.BIT_WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .finished(finished),
    .quotient(quotient), .remainder(remainder), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division semantics in plain integer arithmetic.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == INT_MIN && b == '1) begin
      q = INT_MIN; r = '0; lat = 1;
    end else if (s) begin
      q = W'(sa / sb); r = W'(sa % sb); lat = W + 2;
    end else begin
      q = a / b; r = a % b; lat = W + 2;
    end
  endfunction

  // Every clocked cycle out of reset: a finished cycle must match the queue head,
  // any other cycle must still show the previous result.
  always @(negedge CLK) begin
    if (!nRST) begin
      last_q = '0;
      last_r = '0;
    end else if (finished) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_finished: got finished=1, expected no pending result");
      end else begin
        last_q = exp_q.pop_front();
        last_r = exp_r.pop_front();
        check("quotient", quotient, last_q);
        check("remainder", remainder, last_r);
      end
    end else begin
      check("hold_quotient", quotient, last_q);
      check("hold_remainder", remainder, last_r);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation; optionally re-pulse start with other operands mid-DIVIDE.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit repulse);
    logic [W-1:0] q, r;
    int lat, cycles;
    model(s, a, b, q, r, lat);
    exp_q.push_back(q);
    exp_r.push_back(r);
    wait_idle();
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge CLK);
    #1 start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
    cycles = 0;
    while (cycles < 200) begin
      @(negedge CLK);
      cycles++;
      if (finished) break;
      if (repulse && cycles == 5) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge CLK);
        #1 start = 1'b0;
      end
    end
    check("latency", 32'(cycles), 32'(lat));
  endtask

  task automatic abort_op();
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    wait_idle();
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (10) @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      check("abort_no_finished", 32'(finished), 32'd0);
    end
  endtask

  task automatic pin(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input int el);
    logic [W-1:0] q, r;
    int lat;
    model(s, a, b, q, r, lat);
    check({name, "_q"}, q, eq);
    check({name, "_r"}, r, er);
    check({name, "_lat"}, 32'(lat), 32'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;

    pin("m_divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         34);
    pin("m_div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    pin("m_div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34);
    pin("m_div_x_0",     1'b1, 32'h8000_0005, 32'd0,         32'hFFFF_FFFF, 32'h8000_0005, 1);
    pin("m_div_ovf",     1'b1, INT_MIN,       32'hFFFF_FFFF, INT_MIN,       32'd0,         1);
    pin("m_divu_ovf",    1'b0, INT_MIN,       32'hFFFF_FFFF, 32'd0,         INT_MIN,       34);

    repeat (3) @(negedge CLK);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_finished", 32'(finished), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    nRST = 1'b1;

    run_op(1'b0, 32'd100,       32'd7,         1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(1'b1, 32'd7,         32'hFFFF_FFFE, 1'b0);
    run_op(1'b1, 32'h8000_0005, 32'd0,         1'b0);
    run_op(1'b0, 32'h8000_0005, 32'd0,         1'b0);
    run_op(1'b1, INT_MIN,       32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, INT_MIN,       32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    run_op(1'b1, INT_MIN,       INT_MIN,       1'b0);
    run_op(1'b1, INT_MIN,       32'd2,         1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0);
    run_op(1'b0, 32'd12345678,  32'd1000,      1'b1);

    abort_op();
    run_op(1'b0, 32'd100,       32'd7,         1'b0);

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
